// File: rtl/resistor_capacitor_high_pass_filter.sv
// First-order RC high-pass (DC blocker): y[n] = ALPHA*(y[n-1] + x[n] - x[n-1]), ALPHA in Q16, serial shift-add multiply.
// Build option: define RC_HPF_SATURATE_EN to clamp the result instead of wrapping it to 16 bits.
module resistor_capacitor_high_pass_filter #(
    parameter int SAMPLE_RATE  = 48000,
    parameter int R            = 47000,
    parameter int C_35_SHIFTED = 1615
) (
    input  logic               clk,
    input  logic               I_RSTn,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int SUM_W  = DATA_W + 2;
    localparam int ACC_W  = 35;
    localparam int RES_W  = ACC_W - COEF_W;

    localparam longint DT_32      = (longint'(1) <<< 32) / longint'(SAMPLE_RATE);
    localparam longint RC_32      = (longint'(R) * longint'(C_35_SHIFTED)) >>> 3;
    localparam longint ALPHA_FULL = (RC_32 <<< 16) / (RC_32 + DT_32);
    localparam logic [COEF_W-1:0] ALPHA = (ALPHA_FULL > 65535) ? 16'hFFFF : 16'(ALPHA_FULL);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]               state;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] x_prev;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_load;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  addend;
    logic signed [RES_W-1:0]  res;
    logic [3:0]               cnt;

    function automatic logic signed [DATA_W-1:0] resolve(input logic signed [RES_W-1:0] r);
`ifdef RC_HPF_SATURATE_EN
        if (r > 19'sd32767)
            return 16'sh7FFF;
        else if (r < -19'sd32768)
            return 16'sh8000;
        else
            return 16'(r);
`else
        return 16'(r);
`endif
    endfunction

    // Three 16-bit terms cannot overflow 18 bits, so no guard is needed here.
    assign sum_load = {{2{out[15]}}, out} + {{2{x_cur[15]}}, x_cur} - {{2{x_prev[15]}}, x_prev};
    assign addend   = {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum} <<< cnt;
    assign res      = acc[ACC_W-1:COEF_W];

    // Sample and difference registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && audio_clk_en)
            x_cur <= in;
        if (state == LOAD)
            sum <= sum_load;
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state     <= IDLE;
            x_prev    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            if (audio_clk_en && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (audio_clk_en) begin
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    x_prev <= x_cur;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= MUL;
                end
                // LSB-first over ALPHA: one partial product per clock.
                MUL: begin
                    if (ALPHA[cnt])
                        acc <= acc + addend;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    out       <= resolve(res);
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter.sv
// Bench for resistor_capacitor_high_pass_filter: vector table, directed corner sequences, random samples vs. a reference model.
module tb_resistor_capacitor_high_pass_filter;

    localparam longint TB_ALPHA = 64923;

    logic               clk;
    logic               I_RSTn;
    logic               audio_clk_en;
    logic signed [15:0] in;
    logic signed [15:0] out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    longint model_y  = 0;
    longint model_xp = 0;

    typedef struct {
        logic               rst_before;
        logic signed [15:0] x;
        logic signed [15:0] exp_y;
    } vec_t;

    vec_t vecs[6];

    resistor_capacitor_high_pass_filter dut (
        .clk         (clk),
        .I_RSTn      (I_RSTn),
        .audio_clk_en(audio_clk_en),
        .in          (in),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: y = floor(ALPHA*(y + x - x_prev) / 2^16), then clamp or wrap to 16 bits.
    function automatic longint ref_step(input longint x);
        longint s;
        longint r;
        s = model_y + x - model_xp;
        model_xp = x;
        r = (s * TB_ALPHA) >>> 16;
`ifdef RC_HPF_SATURATE_EN
        if (r > 32767)
            r = 32767;
        else if (r < -32768)
            r = -32768;
`else
        r = r & 64'hFFFF;
        if (r > 32767)
            r = r - 65536;
`endif
        model_y = r;
        return r;
    endfunction

    task automatic apply_reset();
        I_RSTn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            audio_clk_en = 1'($urandom_range(0, 1));
            in = 16'($urandom);
            tick();
            check("rst_out", out, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
        end
        audio_clk_en = 1'b0;
        in = 16'sd0;
        I_RSTn = 1'b1;
        repeat (3) tick();
        check("post_rst_out_hold", out, 0);
        check("post_rst_busy", busy, 0);
        model_y  = 0;
        model_xp = 0;
    endtask

    // Strobe one sample and wait (bounded) for out_valid; lat=0 means it never came.
    task automatic do_sample(input logic signed [15:0] x, output logic signed [15:0] y, output int lat);
        in = x;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        check("busy_after_accept", busy, 1);
        lat = 0;
        y = 16'sd0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                y = out;
                break;
            end
        end
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        logic signed [15:0] y;
        logic signed [15:0] y_hold;
        longint             exp_v;
        int                 lat;
        int                 nv;

        I_RSTn = 1'b0;
        audio_clk_en = 1'b0;
        in = 16'sd0;

        vecs[0] = '{1'b1,  16'sd10000,  16'sd9906};
        vecs[1] = '{1'b0,  16'sd10000,  16'sd9813};
        vecs[2] = '{1'b1, -16'sd10000, -16'sd9907};
        vecs[3] = '{1'b0, -16'sd10000, -16'sd9815};
        vecs[4] = '{1'b1,  16'sd32767,  16'sd32460};
        vecs[5] = '{1'b0, -16'sd32768, -16'sd32766};

        apply_reset();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_before)
                apply_reset();
            do_sample(vecs[i].x, y, lat);
            exp_v = ref_step(longint'(vecs[i].x));
            check("vec_latency", lat, 18);
            check("vec_out", y, vecs[i].exp_y);
            tick();
            check("vec_valid_one_cycle", out_valid, 0);
            check("vec_out_hold", out, y);
        end

        // Second strobe while busy is dropped and flagged.
        apply_reset();
        in = 16'sd10000;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        repeat (4) tick();
        in = -16'sd5555;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        check("ovr_pulse", overrun, 1);
        check("ovr_busy", busy, 1);
        tick();
        check("ovr_clear", overrun, 0);
        nv = 0;
        lat = 0;
        y = 16'sd0;
        for (int k = 7; k <= 45; k++) begin
            tick();
            if (out_valid) begin
                nv++;
                if (lat == 0) begin
                    lat = k;
                    y = out;
                end
            end
        end
        exp_v = ref_step(10000);
        check("ovr_latency", lat, 18);
        check("ovr_result", y, exp_v);
        check("ovr_valid_count", nv, 1);

        // Strobe landing on the DONE cycle is dropped.
        in = 16'sd2000;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        repeat (17) tick();
        in = -16'sd7000;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        exp_v = ref_step(2000);
        check("done_strobe_valid", out_valid, 1);
        check("done_strobe_overrun", overrun, 1);
        check("done_strobe_out", out, exp_v);
        nv = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid)
                nv++;
        end
        check("done_strobe_no_extra", nv, 0);
        check("done_strobe_idle", busy, 0);

        // Reset in the middle of MUL clears history.
        apply_reset();
        do_sample(16'sd10000, y, lat);
        exp_v = ref_step(10000);
        check("midrst_pre_out", y, exp_v);
        in = 16'sd10000;
        audio_clk_en = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        repeat (9) tick();
        I_RSTn = 1'b0;
        #1;
        check("midrst_async_busy", busy, 0);
        check("midrst_async_out", out, 0);
        tick();
        I_RSTn = 1'b1;
        model_y  = 0;
        model_xp = 0;
        tick();
        do_sample(16'sd10000, y, lat);
        check("midrst_latency", lat, 18);
        check("midrst_out", y, 9906);
        exp_v = ref_step(10000);

        // Long negative hold, then a full-scale positive step.
        apply_reset();
        for (int i = 0; i < 1200; i++) begin
            do_sample(-16'sd32768, y, lat);
            exp_v = ref_step(-32768);
            check("sat_hold_out", y, exp_v);
        end
        y_hold = y;
        check("sat_settled_neg", (y_hold < 0) ? 1 : 0, 1);
        do_sample(16'sd32767, y, lat);
        exp_v = ref_step(32767);
        check("sat_step_latency", lat, 18);
        check("sat_step_model", y, exp_v);
`ifdef RC_HPF_SATURATE_EN
        check("sat_step_clamp", y, 32767);
`else
        check("sat_step_wrap_value", y, ((((longint'(y_hold) + 65535) * TB_ALPHA) >>> 16) & 65535) - 65536);
        check("sat_step_wrap_neg", (y < 0) ? 1 : 0, 1);
`endif

        // Random samples, back-to-back or with small gaps.
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            logic signed [15:0] xr;
            case ($urandom_range(0, 5))
                0:       xr = -16'sd32768;
                1:       xr = 16'sd32767;
                default: xr = 16'($urandom);
            endcase
            repeat ($urandom_range(0, 3)) tick();
            do_sample(xr, y, lat);
            exp_v = ref_step(longint'(xr));
            check("rand_latency", lat, 18);
            check("rand_out", y, exp_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
